sev_seg_reader: RTL and testbench

- Observer for a multiplexed 7-segment display bus; the reverse direction of the team's hex-to-segment decoder.
- Samples the segment lines and the one-hot digit enables, and waits for each pattern to hold stable.
- Converts each stable pattern back to its 4-bit hex value, stores it per digit, and flags when a full frame of digits has been read.
- Used in benches and on-chip self-check to close the loop around display drivers.

---
 rtl/sev_seg_pkg.sv | 37 +++
 rtl/sev_seg_pattern_decode.sv | 42 ++++
 rtl/sev_seg_reader.sv | 114 +++++++++++
 tb/tb_sev_seg_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Shared 7-segment definitions: segment bit positions, the 16 hex glyphs
// (same encoding as the hex-to-segment decoder) and the reader FSM states.
package sev_seg_pkg;

  // Bit positions of each segment within the 7-bit bus (a is the MSB).
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Glyphs, bits ordered a..g.
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1110011;
  localparam logic [6:0] SEG_A_HEX = 7'b1110111;
  localparam logic [6:0] SEG_B_HEX = 7'b0011111;
  localparam logic [6:0] SEG_C_HEX = 7'b1001110;
  localparam logic [6:0] SEG_D_HEX = 7'b0111101;
  localparam logic [6:0] SEG_E_HEX = 7'b1001111;
  localparam logic [6:0] SEG_F_HEX = 7'b1000111;

  typedef enum logic {
    COLLECT  = 1'b0,
    COMPLETE = 1'b1
  } state_t;

endpackage

// File: rtl/sev_seg_pattern_decode.sv
// Combinational glyph-to-nibble decoder; exact matches only, anything else
// drops ok.
module sev_seg_pattern_decode
  import sev_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       ok
);

  // Gather segments in a..g order via the named positions so the table below
  // reads the same as the glyph constants.
  logic [6:0] pat;
  assign pat = {seg[SEG_A], seg[SEG_B], seg[SEG_C], seg[SEG_D],
                seg[SEG_E], seg[SEG_F], seg[SEG_G]};

  always_comb begin
    // NOTE: defaults first so every path assigns hex and ok; otherwise a latch is inferred.
    hex = 4'h0;
    ok  = 1'b1;
    case (pat)
      SEG_0:     hex = 4'h0;
      SEG_1:     hex = 4'h1;
      SEG_2:     hex = 4'h2;
      SEG_3:     hex = 4'h3;
      SEG_4:     hex = 4'h4;
      SEG_5:     hex = 4'h5;
      SEG_6:     hex = 4'h6;
      SEG_7:     hex = 4'h7;
      SEG_8:     hex = 4'h8;
      SEG_9:     hex = 4'h9;
      SEG_A_HEX: hex = 4'hA;
      SEG_B_HEX: hex = 4'hB;
      SEG_C_HEX: hex = 4'hC;
      SEG_D_HEX: hex = 4'hD;
      SEG_E_HEX: hex = 4'hE;
      SEG_F_HEX: hex = 4'hF;
      default:   ok  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sev_seg_reader.sv
// Multiplexed 7-segment bus observer: debounces {dig_en, seg_in}, decodes each
// stable glyph into its digit slot and reports frame completion and bad glyphs.
module sev_seg_reader
  import sev_seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_done,
  output logic                  pat_err,
  output logic [IDX_W-1:0]      err_digit
);

  localparam int SW    = DIGITS + 7;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [SW-1:0]     s_q;
  logic [CNT_W-1:0]  cnt;
  state_t            state;

  logic [SW-1:0]     sample;
  logic              same;
  logic              capture;
  logic [DIGITS-1:0] cap_en;
  logic [6:0]        cap_seg;
  logic              en_onehot;
  logic [IDX_W-1:0]  cap_idx;
  logic [3:0]        dec_val;
  logic              dec_ok;

  assign sample  = {dig_en, seg_in};
  assign cap_en  = s_q[SW-1:7];
  assign cap_seg = s_q[6:0];

  // The count tracks how many edges in a row the incoming sample matched the
  // held one; capture fires only on the edge that reaches STABLE_CYCLES.
  assign same    = (sample == s_q);
  assign capture = same && (cnt == CNT_W'(STABLE_CYCLES - 1));

  assign en_onehot = (cap_en != '0) && ((cap_en & (cap_en - 1'b1)) == '0);

  always_comb begin
    cap_idx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (cap_en[k]) cap_idx = IDX_W'(k);
    end
  end

  sev_seg_pattern_decode u_decode (
    .seg (cap_seg),
    .hex (dec_val),
    .ok  (dec_ok)
  );

  // NOTE: non-blocking (<=) for all state so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      cnt         <= '0;
      state       <= COLLECT;
      value       <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      pat_err     <= 1'b0;
      err_digit   <= '0;
    end else begin
      s_q        <= sample;
      frame_done <= 1'b0;
      pat_err    <= 1'b0;

      if (clear) begin
        cnt         <= '0;
        value       <= '0;
        digit_valid <= '0;
        state       <= COLLECT;
      end else begin
        if (!same)
          cnt <= '0;
        else if (cnt != CNT_W'(STABLE_CYCLES))
          cnt <= cnt + 1'b1;

        // A blank enable is the idle phase of the multiplexer, not an error.
        if (capture && (cap_en != '0)) begin
          if (!en_onehot) begin
            pat_err <= 1'b1;
          end else if (dec_ok) begin
            for (int k = 0; k < DIGITS; k++) begin
              if (cap_en[k]) value[4*k +: 4] <= dec_val;
            end
            digit_valid <= digit_valid | cap_en;
            if ((state == COLLECT) && ((digit_valid | cap_en) == '1)) begin
              frame_done <= 1'b1;
              state      <= COMPLETE;
            end
          end else begin
            pat_err     <= 1'b1;
            err_digit   <= cap_idx;
            digit_valid <= digit_valid & ~cap_en;
            state       <= COLLECT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_reader.sv
// Self-checking bench for sev_seg_reader: directed scenarios plus random
// bursts, compared every cycle against a run-length reference model.
module tb_sev_seg_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_en = '0;
  logic        clear = 1'b0;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        pat_err;
  logic [1:0]  err_digit;

  sev_seg_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .IDX_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .clear       (clear),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .pat_err     (pat_err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fd_count = 0;
  int pe_count = 0;

  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Reference model: a pattern is taken when it has been seen on STABLE+1
  // consecutive edges; reset behaves as if zero had been seen once.
  logic [3:0]  m_val [4];
  logic [3:0]  m_valid;
  logic        m_complete;
  logic        m_fd;
  logic        m_pe;
  logic [1:0]  m_errd;
  logic [10:0] m_last;
  int          m_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_val[i] = '0;
    m_valid = '0; m_complete = 1'b0; m_fd = 1'b0; m_pe = 1'b0;
    m_errd = '0; m_last = '0; m_run = 1;
  endtask

  task automatic model_step(input logic [3:0] en, input logic [6:0] seg, input logic clr);
    logic [10:0] x;
    int idx, code;
    x = {en, seg};
    m_fd = 1'b0;
    m_pe = 1'b0;
    if (clr) begin
      m_run = 1;
      for (int i = 0; i < 4; i++) m_val[i] = '0;
      m_valid = '0;
      m_complete = 1'b0;
    end else begin
      m_run = (x == m_last) ? m_run + 1 : 1;
      if (m_run == STABLE + 1 && en != 0) begin
        if ($countones(en) != 1) begin
          m_pe = 1'b1;
        end else begin
          idx = 0;
          for (int i = 0; i < 4; i++) if (en[i]) idx = i;
          code = lookup(seg);
          if (code >= 0) begin
            m_val[idx] = code[3:0];
            m_valid[idx] = 1'b1;
            if (!m_complete && m_valid == 4'hF) begin
              m_fd = 1'b1;
              m_complete = 1'b1;
            end
          end else begin
            m_pe = 1'b1;
            m_errd = idx[1:0];
            m_valid[idx] = 1'b0;
            m_complete = 1'b0;
          end
        end
      end
    end
    m_last = x;
  endtask

  task automatic step(input logic [3:0] en, input logic [6:0] seg, input logic clr);
    dig_en = en; seg_in = seg; clear = clr;
    @(posedge clk);
    model_step(en, seg, clr);
    #1;
    check("value", value, {m_val[3], m_val[2], m_val[1], m_val[0]});
    check("digit_valid", digit_valid, m_valid);
    check("frame_done", frame_done, m_fd);
    check("pat_err", pat_err, m_pe);
    check("err_digit", err_digit, m_errd);
    if (frame_done) fd_count++;
    if (pat_err) pe_count++;
  endtask

  task automatic hold(input logic [3:0] en, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) step(en, seg, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"}, value, 16'h0);
    check({tag, "_valid"}, digit_valid, 4'h0);
    check({tag, "_fd"}, frame_done, 1'b0);
    check({tag, "_pe"}, pat_err, 1'b0);
    check({tag, "_errd"}, err_digit, 2'd0);
  endtask

  initial begin
    int fd0, pe0, n;
    logic [3:0] en;
    logic [6:0] sg;

    model_reset();
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      dig_en = 4'($urandom); seg_in = 7'($urandom);
      @(posedge clk); #1;
      check_all_zero("reset");
    end
    rst_n = 1'b1;

    // Full frame 0..3; frame_done lands on the 5th edge of the digit-3 glyph.
    fd0 = fd_count;
    hold(4'b0001, 7'b1111110, 8);
    hold(4'b0010, 7'b0110000, 8);
    hold(4'b0100, 7'b1101101, 8);
    hold(4'b1000, 7'b1111001, 4);
    check("fd_early", frame_done, 1'b0);
    step(4'b1000, 7'b1111001, 1'b0);
    check("fd_5th_edge", frame_done, 1'b1);
    hold(4'b1000, 7'b1111001, 3);
    check("frame_value", value, 16'h3210);
    check("frame_valid", digit_valid, 4'hF);
    check("frame_pulses", fd_count - fd0, 1);

    fd0 = fd_count;
    hold(4'b0001, 7'b1111110, 8);
    hold(4'b0010, 7'b0110000, 8);
    hold(4'b0100, 7'b1101101, 8);
    hold(4'b1000, 7'b1111001, 8);
    check("second_frame_pulses", fd_count - fd0, 0);

    // Glitch shorter than the stability window.
    fd0 = fd_count; pe0 = pe_count;
    hold(4'b0001, 7'b0110011, 3);
    hold(4'b0001, 7'b1111110, 6);
    check("glitch_nibble0", value[3:0], 4'h0);
    check("glitch_flags", (fd_count - fd0) + (pe_count - pe0), 0);

    // Hex letters after clear.
    step(4'b0000, 7'b0000000, 1'b1);
    fd0 = fd_count;
    hold(4'b0001, 7'b0011111, 8);
    hold(4'b0010, 7'b0111101, 8);
    hold(4'b0100, 7'b1001111, 8);
    hold(4'b1000, 7'b1000111, 8);
    check("letters_value", value, 16'hFEDB);
    check("letters_pulses", fd_count - fd0, 1);

    // Unrecognised glyph on digit 2.
    pe0 = pe_count;
    hold(4'b0100, 7'b0000001, 6);
    check("err_pulses", pe_count - pe0, 1);
    check("err_digit_2", err_digit, 2'd2);
    check("err_valid", digit_valid, 4'b1011);
    check("err_value", value, 16'hFEDB);
    fd0 = fd_count;
    hold(4'b0100, 7'b1001111, 8);
    check("refill_pulses", fd_count - fd0, 1);

    // Multi-hot enable.
    pe0 = pe_count;
    hold(4'b0011, 7'b1111110, 6);
    check("multihot_pulses", pe_count - pe0, 1);
    check("multihot_errd", err_digit, 2'd2);
    check("multihot_value", value, 16'hFEDB);

    // Clear on the exact capture edge.
    hold(4'b0000, 7'b0000000, 2);
    step(4'b0000, 7'b0000000, 1'b1);
    hold(4'b0001, 7'b1111110, 4);
    step(4'b0001, 7'b1111110, 1'b1);
    check("clear_cap_valid", digit_valid, 4'h0);
    check("clear_cap_fd", frame_done, 1'b0);
    hold(4'b0000, 7'b0000000, 6);
    check("clear_cap_after", digit_valid, 4'h0);

    // Random bursts.
    for (int b = 0; b < 300; b++) begin
      n = $urandom_range(1, 8);
      case ($urandom_range(0, 9))
        0:       en = 4'b0000;
        1:       en = 4'b0011 << $urandom_range(0, 2);
        2:       en = 4'($urandom);
        default: en = 4'b0001 << $urandom_range(0, 3);
      endcase
      sg = ($urandom_range(0, 4) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      for (int i = 0; i < n; i++) step(en, sg, ($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset mid-frame: outputs drop before the next edge.
    hold(4'b0001, 7'b0110000, 8);
    hold(4'b0010, 7'b1110000, 3);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold(4'b0001, 7'b1011011, 6);
    check("post_rst_value", value, 16'h0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
